// File: rtl/shader_timing_pkg.sv
// Shared types and default VGA 640x480@60 timing for the shader video timing block.
package shader_timing_pkg;

   typedef enum logic [1:0] {
      TM_PINGPONG = 2'd0,
      TM_WRAP     = 2'd1,
      TM_HOLD     = 2'd2,
      TM_CLEAR    = 2'd3
   } time_mode_e;

   localparam int VGA_WIDTH  = 640;
   localparam int VGA_HEIGHT = 480;
   localparam int VGA_HFRONT = 16;
   localparam int VGA_HSYNC  = 96;
   localparam int VGA_HBACK  = 48;
   localparam int VGA_VFRONT = 10;
   localparam int VGA_VSYNC  = 2;
   localparam int VGA_VBACK  = 33;

   function automatic int axis_total(input int res, input int front, input int sync, input int back);
      return res + front + sync + back;
   endfunction

endpackage

// File: rtl/axis_counter.sv
// One timing axis: wrapping position counter with sync, blank and wrap strobe.
module axis_counter
   import shader_timing_pkg::*;
#(
   parameter int  RES   = VGA_WIDTH,
   parameter int  FRONT = VGA_HFRONT,
   parameter int  SYNC  = VGA_HSYNC,
   parameter int  BACK  = VGA_HBACK,
   parameter bit  POL   = 1'b1,
   localparam int TOTAL = axis_total(RES, FRONT, SYNC, BACK),
   localparam int W     = $clog2(TOTAL)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         step_i,
   output logic [W-1:0] count_o,
   output logic         sync_o,
   output logic         blank_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST = W'(TOTAL - 1);

   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;
   logic [31:0]  count_ext;
   logic         last;
   logic         sync_active;

   assign last = (count_reg == LAST);

   always_comb begin
      count_next = count_reg;
      if (step_i) begin
         count_next = last ? '0 : count_reg + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // Compare in 32 bits so a sync window ending exactly at TOTAL cannot overflow W.
   assign count_ext   = 32'(count_reg);
   assign sync_active = (count_ext >= 32'(RES + FRONT)) && (count_ext < 32'(RES + FRONT + SYNC));

   assign count_o = count_reg;
   assign sync_o  = POL ? sync_active : ~sync_active;
   assign blank_o = (count_ext >= 32'(RES));
   assign wrap_o  = step_i & last;

endmodule

// File: rtl/shader_video_timing.sv
// Video timing, prefetch-shifted downscaled execute coordinates and animation time
// for the shader pipeline.
module shader_video_timing
   import shader_timing_pkg::*;
#(
   parameter int  WIDTH      = VGA_WIDTH,
   parameter int  HEIGHT     = VGA_HEIGHT,
   parameter int  HFRONT     = VGA_HFRONT,
   parameter int  HSYNC      = VGA_HSYNC,
   parameter int  HBACK      = VGA_HBACK,
   parameter int  VFRONT     = VGA_VFRONT,
   parameter int  VSYNC      = VGA_VSYNC,
   parameter int  VBACK      = VGA_VBACK,
   parameter bit  H_POL      = 1'b1,
   parameter bit  V_POL      = 1'b1,
   parameter int  SCALE_LOG2 = 3,
   parameter int  PREFETCH   = 8,
   parameter int  TIME_W     = 8,
   localparam int HTOTAL     = axis_total(WIDTH, HFRONT, HSYNC, HBACK),
   localparam int VTOTAL     = axis_total(HEIGHT, VFRONT, VSYNC, VBACK),
   localparam int HW         = $clog2(HTOTAL),
   localparam int VW         = $clog2(VTOTAL)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic [1:0]             time_mode_i,
   input  logic [3:0]             time_step_i,
   output logic                   hsync_o,
   output logic                   vsync_o,
   output logic                   blank_o,
   output logic                   line_end_o,
   output logic                   frame_end_o,
   output logic [HW-1:0]          x_o,
   output logic [VW-1:0]          y_o,
   output logic                   execute_o,
   output logic [HW-SCALE_LOG2-1:0] x_exec_o,
   output logic [VW-SCALE_LOG2-1:0] y_exec_o,
   output logic [TIME_W-1:0]      time_o,
   output logic                   time_dir_o
);

   logic h_blank;
   logic v_blank;

   axis_counter #(
      .RES   (WIDTH),
      .FRONT (HFRONT),
      .SYNC  (HSYNC),
      .BACK  (HBACK),
      .POL   (H_POL)
   ) u_h_axis (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .step_i  (enable_i),
      .count_o (x_o),
      .sync_o  (hsync_o),
      .blank_o (h_blank),
      .wrap_o  (line_end_o)
   );

   // The vertical axis steps on line end, so its wrap strobe is the frame end.
   axis_counter #(
      .RES   (HEIGHT),
      .FRONT (VFRONT),
      .SYNC  (VSYNC),
      .BACK  (VBACK),
      .POL   (V_POL)
   ) u_v_axis (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .step_i  (line_end_o),
      .count_o (y_o),
      .sync_o  (vsync_o),
      .blank_o (v_blank),
      .wrap_o  (frame_end_o)
   );

   assign blank_o = h_blank | v_blank;

   logic [HW:0]   x_sum;
   logic [HW-1:0] xe;
   logic [VW-1:0] ye;
   logic          y_last;

   assign x_sum  = {1'b0, x_o} + (HW+1)'(PREFETCH);
   assign y_last = (y_o == VW'(VTOTAL - 1));

   // A lead that runs past the end of the line lands on the next line.
   always_comb begin
      xe = x_sum[HW-1:0];
      ye = y_o;
      if (x_sum >= (HW+1)'(HTOTAL)) begin
         xe = HW'(x_sum - (HW+1)'(HTOTAL));
         ye = y_last ? '0 : y_o + VW'(1);
      end
   end

   assign execute_o = (xe < HW'(WIDTH)) && (ye < VW'(HEIGHT));
   assign x_exec_o  = xe[HW-1:SCALE_LOG2];
   assign y_exec_o  = ye[VW-1:SCALE_LOG2];

   localparam logic [TIME_W-1:0] TIME_MAX = '1;

   time_mode_e        mode;
   logic [TIME_W-1:0] time_reg;
   logic [TIME_W-1:0] time_next;
   logic              dir_reg;
   logic              dir_next;
   logic [TIME_W:0]   step_wide;
   logic [TIME_W:0]   time_sum;

   assign mode      = time_mode_e'(time_mode_i);
   assign step_wide = (TIME_W+1)'(time_step_i);
   assign time_sum  = {1'b0, time_reg} + step_wide;

   always_comb begin
      time_next = time_reg;
      dir_next  = dir_reg;
      if (mode == TM_CLEAR) begin
         time_next = '0;
         dir_next  = 1'b0;
      end else if (frame_end_o) begin
         case (mode)
            TM_PINGPONG: begin
               if (!dir_reg) begin
                  if (time_sum >= {1'b0, TIME_MAX}) begin
                     time_next = TIME_MAX;
                     dir_next  = 1'b1;
                  end else begin
                     time_next = time_sum[TIME_W-1:0];
                  end
               end else begin
                  if ({1'b0, time_reg} <= step_wide) begin
                     time_next = '0;
                     dir_next  = 1'b0;
                  end else begin
                     time_next = TIME_W'({1'b0, time_reg} - step_wide);
                  end
               end
            end
            TM_WRAP: begin
               time_next = time_sum[TIME_W-1:0];
               dir_next  = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         time_reg <= '0;
         dir_reg  <= 1'b0;
      end else begin
         time_reg <= time_next;
         dir_reg  <= dir_next;
      end
   end

   assign time_o     = time_reg;
   assign time_dir_o = dir_reg;

endmodule

// File: doc/shader_video_timing.md
Name: shader_video_timing

Overview:
Parametrised video timing and coordinate generator for the shader pipeline. It replaces the fixed 640x480 horizontal/vertical timing pair, the ad-hoc execute window and the hard-wired ping-pong frame-time counter with one configurable block. It drives the sync/blank outputs, the display coordinates, the prefetch-shifted downscaled execution coordinates consumed by shader_execute, and a multi-mode animation time value.

Parameters:
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines per frame
HFRONT / HSYNC / HBACK, 16 / 96 / 48, horizontal porch and sync lengths in cycles
VFRONT / VSYNC / VBACK, 10 / 2 / 33, vertical porch and sync lengths in lines
H_POL / V_POL, 1 / 1, sync polarity; 1 = active high, 0 = active low
SCALE_LOG2, 3, downscale factor log2; one shader pixel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 display pixels
PREFETCH, 8, cycles by which the execution coordinate leads the display; must be >= 0 and < HFRONT+HSYNC+HBACK
TIME_W, 8, width of the animation time value

Derived values:
- HTOTAL = WIDTH+HFRONT+HSYNC+HBACK
- VTOTAL = HEIGHT+VFRONT+VSYNC+VBACK
- HW = $clog2(HTOTAL)
- VW = $clog2(VTOTAL)

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  reset; asynchronous, active-low
enable_i  in  1  advance the timing counters this cycle
time_mode_i  in  2  0 ping-pong, 1 wrap, 2 hold, 3 clear
time_step_i  in  4  per-frame time increment, unsigned
hsync_o  out  1  horizontal sync, level per H_POL
vsync_o  out  1  vertical sync, level per V_POL
blank_o  out  1  outside the visible area
line_end_o  out  1  single-cycle strobe at the last cycle of a line
frame_end_o  out  1  single-cycle strobe at the last cycle of a frame
x_o  out  HW  display column counter
y_o  out  VW  display line counter
execute_o  out  1  shader executes this cycle
x_exec_o  out  HW-SCALE_LOG2  execution column in shader pixels
y_exec_o  out  VW-SCALE_LOG2  execution line in shader pixels
time_o  out  TIME_W  animation time value
time_dir_o  out  1  ping-pong direction; 0 = up, 1 = down

Behaviour:
Reset values:
- x_o = 0, y_o = 0, time_o = 0, time_dir_o = 0.
- Derived outputs follow from these counters: hsync_o = ~H_POL, vsync_o = ~V_POL, blank_o = 0, strobes = 0, execute_o = 1.
- With PREFETCH=8 and SCALE_LOG2=3: x_exec_o = 1, y_exec_o = 0.

Timing counters:
- x_o, y_o, time_o and time_dir_o are the only registers. Every other output is a combinational function of them and of enable_i; there is no other input-to-output path.
- When enable_i=1, x increments; x = HTOTAL-1 wraps to 0 and advances y. y = VTOTAL-1 wraps to 0.
- When enable_i=0, all counters hold and line_end_o / frame_end_o are 0.
- line_end_o = enable_i & (x == HTOTAL-1).
- frame_end_o = line_end_o & (y == VTOTAL-1).
- hsync is active for x in [WIDTH+HFRONT, WIDTH+HFRONT+HSYNC); vsync is active for y in [HEIGHT+VFRONT, HEIGHT+VFRONT+VSYNC).
- blank_o = (x >= WIDTH) | (y >= HEIGHT).

Execution coordinates:
- xe = x+PREFETCH when x+PREFETCH < HTOTAL; otherwise xe = x+PREFETCH-HTOTAL and ye is the next line (y+1, with VTOTAL-1 wrapping to 0). Otherwise ye = y.
- execute_o = (xe < WIDTH) & (ye < HEIGHT).
- x_exec_o = xe >> SCALE_LOG2; y_exec_o = ye >> SCALE_LOG2.
- Outside the execute window, x_exec_o and y_exec_o are don't-care.

Time counter update rules:
- The counter updates only on frame_end_o, except mode 3.
- Mode 3 (clear): time_o and time_dir_o are forced to 0 on every cycle, independent of frame_end_o.
- Mode 0 (ping-pong), direction up: if time+step >= 2^TIME_W-1, then time = max and dir = 1; else time += step.
- Mode 0 (ping-pong), direction down: if time <= step, then time = 0 and dir = 0; else time -= step.
- Mode 1 (wrap): time = (time+step) mod 2^TIME_W; dir = 0.
- Mode 2 (hold): no change.
- time_step_i = 0 in mode 0 or 1 leaves time_o unchanged.
- A time_mode_i change takes effect at the next qualifying update.

Reset mid-frame: all registers return to their reset values immediately; there is no partial-line completion.

Decomposition:
- Package shader_timing_pkg contains:
  - the time_mode_e enum (TM_PINGPONG, TM_WRAP, TM_HOLD, TM_CLEAR);
  - VGA 640x480@60 default constants;
  - the derived HTOTAL/VTOTAL helpers.
- One sub-module, axis_counter, is instantiated twice (horizontal and vertical). It is parametrised by RES/FRONT/SYNC/BACK/POL and provides the counter, sync, blank and wrap strobe.
- The execute-window logic and the time logic stay in the top.

Test Plan:
- Reset with defaults -> x_o=0, y_o=0, hsync_o=0, vsync_o=0, blank_o=0, execute_o=1, x_exec_o=1, time_o=0.
- Free run with defaults -> hsync_o=1 exactly for x=656..751; vsync_o=1 exactly for y=490..491; frame_end_o pulses every 420000 cycles at (799,524).
- At x=792, y=524 -> execute_o=1, x_exec_o=0, y_exec_o=0. At x=632, y=0 -> execute_o=0. At x=631, y=479 -> execute_o=1, x_exec_o=79, y_exec_o=59.
- Mode 0 (ping-pong):
  - step=1 from 0: 255 frames reach time_o=255 with time_dir_o=1; the next frame gives 254.
  - step=5 at time 252, direction up -> 255, dir 1.
  - Direction down at time 3, step 5 -> 0, dir 0.
- Mode 1 (wrap), step=4, at time 254 -> time_o=2. Mode 2 -> unchanged across 3 frames. Mode 3 asserted mid-frame -> time_o=0 next cycle.
- Reduced parameters (WIDTH=16, HEIGHT=8, porches 2/2/2, H_POL=0):
  - enable_i low for 10 cycles -> x/y hold and strobes stay 0;
  - rst_ni pulsed at (x=5, y=3) -> all outputs at reset values with no clock edge.
